// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-stage forwarding select and load-use stall generator
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters)
// Select encoding: 2'd0 FW_NONE, 2'd1 FW_MEM_ALU, 2'd2 FW_WB_DATA
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ID_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs2_addr_i,
    input  logic                      ID_uses_rs1_i,
    input  logic                      ID_uses_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rd_addr_i,
    input  logic                      ID_RegWrite_i,
    input  logic                      ID_MemRead_i,
    input  logic                      EX_flush_i,
    output logic [1:0]                EX_forwardA_o,
    output logic [1:0]                EX_forwardB_o,
    output logic                      stall_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    localparam logic [1:0] FW_NONE    = 2'd0;
    localparam logic [1:0] FW_MEM_ALU = 2'd1;
    localparam logic [1:0] FW_WB_DATA = 2'd2;

    // EX slot: instruction one stage ahead of ID
    logic                      r_ex_valid;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
    logic                      r_ex_regwrite;
    logic                      r_ex_memread;

    // MEM slot: only the writer fields matter here, a load in MEM is already forwardable.
    // No WB slot is kept: the register file writes before it reads, so WB never needs a bypass.
    logic                      r_mem_valid;
    logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
    logic                      r_mem_regwrite;

    logic [1:0]                r_fwd_a;
    logic [1:0]                r_fwd_b;

    logic w_ex_rs1;
    logic w_ex_rs2;
    logic w_mem_rs1;
    logic w_mem_rs2;
    logic w_stall;
    logic w_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Writer matches; rd!=0 also rules out x0 as a source
    assign w_ex_rs1  = r_ex_valid & r_ex_regwrite & (r_ex_rd != '0)
                     & (r_ex_rd == ID_rs1_addr_i) & ID_uses_rs1_i;
    assign w_ex_rs2  = r_ex_valid & r_ex_regwrite & (r_ex_rd != '0)
                     & (r_ex_rd == ID_rs2_addr_i) & ID_uses_rs2_i;
    assign w_mem_rs1 = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0)
                     & (r_mem_rd == ID_rs1_addr_i) & ID_uses_rs1_i;
    assign w_mem_rs2 = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0)
                     & (r_mem_rd == ID_rs2_addr_i) & ID_uses_rs2_i;

    // A load one stage ahead cannot be bypassed from MEM, so hold ID one cycle; flush wins
    assign w_stall  = ID_valid_i & ~EX_flush_i & r_ex_memread & (w_ex_rs1 | w_ex_rs2);
    assign w_bubble = w_stall | EX_flush_i | ~ID_valid_i;
    assign stall_o  = w_stall;

    // Next-cycle operand selects, youngest producer first
    always_comb begin
        w_fwd_a = FW_NONE;
        w_fwd_b = FW_NONE;
        if (!w_bubble) begin
            if (w_ex_rs1 && !r_ex_memread) begin
                w_fwd_a = FW_MEM_ALU;
            end else if (w_mem_rs1) begin
                w_fwd_a = FW_WB_DATA;
            end
            if (w_ex_rs2 && !r_ex_memread) begin
                w_fwd_b = FW_MEM_ALU;
            end else if (w_mem_rs2) begin
                w_fwd_b = FW_WB_DATA;
            end
        end
    end

    // Advance the slot pipeline and register the selects alongside the EX slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_fwd_a        <= FW_NONE;
            r_fwd_b        <= FW_NONE;
        end else begin
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            if (w_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_rd       <= ID_rd_addr_i;
                r_ex_regwrite <= ID_RegWrite_i;
                r_ex_memread  <= ID_MemRead_i;
            end
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign EX_forwardA_o = r_fwd_a;
    assign EX_forwardB_o = r_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    // Saturating event counters for stall and flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (EX_flush_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed testbench for hazard_forward_unit
module tb_hazard_forward_unit;

    localparam logic [1:0] FW_NONE    = 2'd0;
    localparam logic [1:0] FW_MEM_ALU = 2'd1;
    localparam logic [1:0] FW_WB_DATA = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_valid_i;
    logic [4:0]  ID_rs1_addr_i;
    logic [4:0]  ID_rs2_addr_i;
    logic        ID_uses_rs1_i;
    logic        ID_uses_rs2_i;
    logic [4:0]  ID_rd_addr_i;
    logic        ID_RegWrite_i;
    logic        ID_MemRead_i;
    logic        EX_flush_i;
    logic [1:0]  EX_forwardA_o;
    logic [1:0]  EX_forwardB_o;
    logic        stall_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_stalls = 0;
    int exp_flushes = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ID_valid_i    (ID_valid_i),
        .ID_rs1_addr_i (ID_rs1_addr_i),
        .ID_rs2_addr_i (ID_rs2_addr_i),
        .ID_uses_rs1_i (ID_uses_rs1_i),
        .ID_uses_rs2_i (ID_uses_rs2_i),
        .ID_rd_addr_i  (ID_rd_addr_i),
        .ID_RegWrite_i (ID_RegWrite_i),
        .ID_MemRead_i  (ID_MemRead_i),
        .EX_flush_i    (EX_flush_i),
        .EX_forwardA_o (EX_forwardA_o),
        .EX_forwardB_o (EX_forwardB_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic fl);
        ID_valid_i    = v;
        ID_rs1_addr_i = rs1;
        ID_uses_rs1_i = u1;
        ID_rs2_addr_i = rs2;
        ID_uses_rs2_i = u2;
        ID_rd_addr_i  = rd;
        ID_RegWrite_i = rw;
        ID_MemRead_i  = mr;
        EX_flush_i    = fl;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_id(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check stall mid-cycle, then take one clock edge
    task automatic clk_step(input string tag, input logic exp_stall);
        @(negedge clk);
        check_eq({tag, "_stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
    endtask

    task automatic check_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
        check_eq({tag, "_fwdA"}, {30'd0, EX_forwardA_o}, {30'd0, a});
        check_eq({tag, "_fwdB"}, {30'd0, EX_forwardB_o}, {30'd0, b});
    endtask

    task automatic drain();
        idle();
        repeat (3) clk_step("drain", 1'b0);
    endtask

    initial begin
        // Reset with random ID fields
        rst = 1'b1;
        set_id(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom),
               1'b1, 1'($urandom), 1'($urandom));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_sel("reset", FW_NONE, FW_NONE);
        check_eq("reset_stall", {31'd0, stall_o}, 32'd0);
        check_eq("reset_stall_cnt", stall_cnt_o, 32'd0);
        check_eq("reset_flush_cnt", flush_cnt_o, 32'd0);
        rst = 1'b0;
        drain();

        // Reset mid-operation kills the in-flight producer
        alu(5'd5, 5'd1, 5'd2);
        clk_step("rstmid_p", 1'b0);
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        alu(5'd6, 5'd5, 5'd5);
        clk_step("rstmid_c", 1'b0);
        check_sel("rstmid", FW_NONE, FW_NONE);
        drain();

        // EX->MEM: add x5; add x6,x5,x7
        alu(5'd5, 5'd1, 5'd2);
        clk_step("exmem_p", 1'b0);
        check_sel("exmem_p", FW_NONE, FW_NONE);
        alu(5'd6, 5'd5, 5'd7);
        clk_step("exmem_c", 1'b0);
        check_sel("exmem", FW_MEM_ALU, FW_NONE);
        drain();

        // MEM->WB: add x5; nop; sub x8,x7,x5
        alu(5'd5, 5'd1, 5'd2);
        clk_step("memwb_p", 1'b0);
        idle();
        clk_step("memwb_nop", 1'b0);
        alu(5'd8, 5'd7, 5'd5);
        clk_step("memwb_c", 1'b0);
        check_sel("memwb", FW_NONE, FW_WB_DATA);
        drain();

        // Priority: add x5; add x5; or x9,x5,x5
        alu(5'd5, 5'd1, 5'd2);
        clk_step("prio_p1", 1'b0);
        alu(5'd5, 5'd3, 5'd4);
        clk_step("prio_p2", 1'b0);
        alu(5'd9, 5'd5, 5'd5);
        clk_step("prio_c", 1'b0);
        check_sel("prio", FW_MEM_ALU, FW_MEM_ALU);
        drain();

        // Load-use: lw x5; add x6,x5,x1 -> one stall, then WB forward
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        clk_step("lu_load", 1'b0);
        alu(5'd6, 5'd5, 5'd1);
        clk_step("lu_first", 1'b1);
        exp_stalls++;
        check_sel("lu_bubble", FW_NONE, FW_NONE);
        clk_step("lu_second", 1'b0);
        check_sel("lu_held", FW_WB_DATA, FW_NONE);
        drain();

        // x0: addi x0 then add x1,x0,x0
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        clk_step("x0_p", 1'b0);
        alu(5'd1, 5'd0, 5'd0);
        clk_step("x0_c", 1'b0);
        check_sel("x0", FW_NONE, FW_NONE);
        drain();

        // x0 load never stalls
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        clk_step("x0ld_p", 1'b0);
        alu(5'd1, 5'd0, 5'd0);
        clk_step("x0ld_c", 1'b0);
        check_sel("x0ld", FW_NONE, FW_NONE);
        drain();

        // Flush beats stall: lw x5; add x6,x5,x5 with flush; then add x7,x6,x0
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        clk_step("fl_load", 1'b0);
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        clk_step("fl_dep", 1'b0);
        exp_flushes++;
        check_sel("fl_bubble", FW_NONE, FW_NONE);
        alu(5'd7, 5'd6, 5'd0);
        clk_step("fl_after", 1'b0);
        check_sel("fl_after", FW_NONE, FW_NONE);
        drain();

        // Performance counters
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt_o, 32'(exp_stalls));
        check_eq("flush_cnt", flush_cnt_o, 32'(exp_flushes));
`else
        check_eq("stall_cnt_off", stall_cnt_o, 32'd0);
        check_eq("flush_cnt_off", flush_cnt_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
